// File: rtl/fp_mul_sched.sv
// Round-robin scheduler sharing one fixed-latency fp_mul datapath between NREQ requesters.
// One operation in flight; operands are registered onto the multiplier and the result is returned to its owner.
module fp_mul_sched #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned MUL_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_x,
    input  logic [32*NREQ-1:0]   req_y,
    input  logic [3*NREQ-1:0]    req_rm,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [31:0]          rsp_z,
    output logic [4:0]           rsp_flags,
    output logic [31:0]          mul_x,
    output logic [31:0]          mul_y,
    output logic [2:0]           mul_rm,
    input  logic [31:0]          mul_z,
    input  logic [4:0]           mul_flags,
    output logic                 busy,
    output logic [15:0]          ops_done
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   rr_q;
    logic [IDX_W-1:0]   owner_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        mul_x_q;
    logic [31:0]        mul_y_q;
    logic [2:0]         mul_rm_q;
    logic [31:0]        rsp_z_q;
    logic [4:0]         rsp_flags_q;
    logic [NREQ-1:0]    rsp_valid_q;
    logic               busy_q;
    logic [15:0]        ops_done_q;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   cand_idx;
    int unsigned        cand;
    logic [31:0]        win_x;
    logic [31:0]        win_y;
    logic [2:0]         win_rm;
    logic [IDX_W-1:0]   rr_next;

    // Round-robin search: first valid requester at or above rr, wrapping modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = 32'(rr_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = IDX_W'(cand);
            if (!win_found && req_valid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        win_x  = req_x[32*win_idx +: 32];
        win_y  = req_y[32*win_idx +: 32];
        win_rm = req_rm[3*win_idx +: 3];
    end

    always_comb begin
        rr_next = win_idx + IDX_W'(1);
        if (win_idx == IDX_W'(NREQ - 1)) begin
            rr_next = '0;
        end
    end

    // Grant is only offered in IDLE and is forced low while reset is held.
    always_comb begin
        req_ready = '0;
        if (!rst && state_q == IDLE && win_found) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            mul_x_q     <= '0;
            mul_y_q     <= '0;
            mul_rm_q    <= '0;
            rsp_z_q     <= '0;
            rsp_flags_q <= '0;
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
            ops_done_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        mul_x_q  <= win_x;
                        mul_y_q  <= win_y;
                        mul_rm_q <= win_rm;
                        owner_q  <= win_idx;
                        rr_q     <= rr_next;
                        cnt_q    <= CNT_W'(MUL_LAT - 1);
                        busy_q   <= 1'b1;
                        state_q  <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        rsp_z_q     <= mul_z;
                        rsp_flags_q <= mul_flags;
                        rsp_valid_q <= NREQ'(1) << owner_q;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    // Only the owner's ready bit can retire the response.
                    if (rsp_ready[owner_q]) begin
                        rsp_valid_q <= '0;
                        busy_q      <= 1'b0;
                        ops_done_q  <= ops_done_q + 16'd1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mul_x     = mul_x_q;
    assign mul_y     = mul_y_q;
    assign mul_rm    = mul_rm_q;
    assign rsp_z     = rsp_z_q;
    assign rsp_flags = rsp_flags_q;
    assign rsp_valid = rsp_valid_q;
    assign busy      = busy_q;
    assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_fp_mul_sched.sv
// Randomized self-checking bench for fp_mul_sched with a transaction-level scheduling model
// and a stand-in multiplier whose result is only valid in the exact capture cycle.
module tb_fp_mul_sched;

    localparam int unsigned NREQ = 3;
    localparam int unsigned LATP = 3;
    localparam int N   = NREQ;
    localparam int LAT = LATP;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [32*NREQ-1:0]  req_x;
    logic [32*NREQ-1:0]  req_y;
    logic [3*NREQ-1:0]   req_rm;
    logic [NREQ-1:0]     rsp_valid;
    logic [NREQ-1:0]     rsp_ready;
    logic [31:0]         rsp_z;
    logic [4:0]          rsp_flags;
    logic [31:0]         mul_x;
    logic [31:0]         mul_y;
    logic [2:0]          mul_rm;
    logic [31:0]         mul_z;
    logic [4:0]          mul_flags;
    logic                busy;
    logic [15:0]         ops_done;

    always #5 clk = ~clk;

    fp_mul_sched #(.NREQ(NREQ), .MUL_LAT(LATP)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_rm    (req_rm),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_z     (rsp_z),
        .rsp_flags (rsp_flags),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_rm    (mul_rm),
        .mul_z     (mul_z),
        .mul_flags (mul_flags),
        .busy      (busy),
        .ops_done  (ops_done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // Reference model state: pending ops per requester and the single in-flight transaction.
    logic [NREQ-1:0] pend;
    logic [31:0]     ox [NREQ];
    logic [31:0]     oy [NREQ];
    logic [2:0]      orm [NREQ];
    bit              in_flight;
    int              cyc;
    int              acc_cyc;
    int              own;
    int              last_w;
    int              ops;
    logic [31:0]     cx;
    logic [31:0]     cy;
    logic [2:0]      crm;
    bit              acc_next;
    bit              done_next;
    int              nxt_w;
    bit              gen_en;
    bit              rdy_all;
    int              bp;

    // Stand-in multiplier: exact for the directed cases, an operand hash otherwise.
    function automatic logic [36:0] mul_model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] r);
        if (x[30:0] == 31'd0 || y[30:0] == 31'd0) begin
            return {5'b00100, x[31] ^ y[31], 31'd0};
        end
        if (x == 32'h40400000 && y == 32'h40400000) begin
            return {5'b00000, 32'h41100000};
        end
        return {x[4:0] ^ y[9:5] ^ {2'b00, r}, x ^ {y[15:0], y[15:0]} ^ {29'd0, r}};
    endfunction

    // Fair order: first pending requester strictly after the last one served.
    function automatic int pick(input logic [NREQ-1:0] v, input int last);
        int i;
        for (int d = 1; d <= N; d++) begin
            i = (last + d) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic new_op(input int i);
        ox[i]  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
        oy[i]  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
        orm[i] = 3'($urandom_range(0, 7));
        pend[i] = 1'b1;
    endtask

    task automatic drive_reqs();
        req_valid = pend;
        for (int i = 0; i < N; i++) begin
            req_x[32*i +: 32] = ox[i];
            req_y[32*i +: 32] = oy[i];
            req_rm[3*i +: 3]  = orm[i];
        end
    endtask

    task automatic model_reset();
        in_flight = 1'b0;
        acc_cyc   = 0;
        own       = 0;
        last_w    = N - 1;
        ops       = 0;
        cx        = 32'd0;
        cy        = 32'd0;
        crm       = 3'd0;
        acc_next  = 1'b0;
        done_next = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_req_ready", req_ready, '0);
        check("rst_rsp_valid", rsp_valid, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_mul_x", mul_x, 32'd0);
        check("rst_mul_y", mul_y, 32'd0);
        check("rst_mul_rm", mul_rm, 3'd0);
        check("rst_rsp_z", rsp_z, 32'd0);
        check("rst_rsp_flags", rsp_flags, 5'd0);
        check("rst_ops_done", ops_done, 16'd0);
    endtask

    task automatic check_cycle();
        logic [NREQ-1:0] exp_rdy;
        logic [NREQ-1:0] exp_rv;
        logic [36:0]     exp_res;
        int              w;
        exp_rdy = '0;
        exp_rv  = '0;
        w = pick(pend, last_w);
        if (!in_flight && w >= 0) exp_rdy[w] = 1'b1;
        check("req_ready", req_ready, exp_rdy);
        check("busy", busy, in_flight);
        if (in_flight && (cyc - acc_cyc) >= LAT) exp_rv[own] = 1'b1;
        check("rsp_valid", rsp_valid, exp_rv);
        if (exp_rv != '0) begin
            exp_res = mul_model(cx, cy, crm);
            check("rsp_z", rsp_z, exp_res[31:0]);
            check("rsp_flags", rsp_flags, exp_res[36:32]);
        end
        check("mul_x", mul_x, cx);
        check("mul_y", mul_y, cy);
        check("mul_rm", mul_rm, crm);
        check("ops_done", ops_done, 16'(ops));
        acc_next  = !in_flight && (w >= 0);
        nxt_w     = w;
        done_next = (exp_rv != '0) && rsp_ready[own];
    endtask

    task automatic step();
        int k;
        @(posedge clk);
        cyc++;
        if (acc_next) begin
            in_flight = 1'b1;
            acc_cyc   = cyc;
            own       = nxt_w;
            cx        = ox[own];
            cy        = oy[own];
            crm       = orm[own];
            pend[own] = 1'b0;
            last_w    = own;
        end
        if (done_next) begin
            in_flight = 1'b0;
            ops++;
        end
        acc_next  = 1'b0;
        done_next = 1'b0;
        #1;
        if (gen_en) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) new_op(i);
            end
        end
        drive_reqs();
        if (bp > 0 && in_flight && (cyc - acc_cyc) >= LAT) begin
            rsp_ready      = '1;
            rsp_ready[own] = 1'b0;
            bp--;
        end else if (rdy_all) begin
            rsp_ready = '1;
        end else begin
            rsp_ready = NREQ'($urandom);
        end
        k = cyc - acc_cyc;
        if (in_flight && k == LAT - 1) begin
            {mul_flags, mul_z} = mul_model(cx, cy, crm);
        end else begin
            mul_z     = $urandom;
            mul_flags = 5'($urandom);
        end
        @(negedge clk);
        check_cycle();
    endtask

    initial begin
        bit found;
        rst       = 1'b1;
        pend      = '0;
        for (int i = 0; i < N; i++) begin
            ox[i] = 32'd0; oy[i] = 32'd0; orm[i] = 3'd0;
        end
        drive_reqs();
        rsp_ready = '0;
        mul_z     = 32'd0;
        mul_flags = 5'd0;
        gen_en    = 1'b0;
        rdy_all   = 1'b1;
        bp        = 0;
        cyc       = 0;
        model_reset();
        #3;
        req_valid = '1;
        #1;
        check_reset_values();
        req_valid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single request: 3.0 * 3.0 with RTZ from requester 0.
        ox[0] = 32'h40400000; oy[0] = 32'h40400000; orm[0] = 3'b001; pend[0] = 1'b1;
        repeat (8) step();
        check("single_ops_done", ops_done, 16'd1);

        // Zero operand from requester 1.
        ox[1] = 32'h00000000; oy[1] = 32'h40490FDB; orm[1] = 3'b000; pend[1] = 1'b1;
        repeat (8) step();
        check("zero_ops_done", ops_done, 16'd2);

        // Backpressure: owner holds rsp_ready low for 5 response cycles.
        new_op(1);
        bp = 5;
        repeat (14) step();
        check("bp_ops_done", ops_done, 16'd3);

        // Contention with every requester busy, then fully random traffic.
        for (int i = 0; i < N; i++) new_op(i);
        gen_en = 1'b1;
        repeat (40) step();
        rdy_all = 1'b0;
        repeat (300) step();

        // Reset while an operation sits in WAIT.
        found = 1'b0;
        for (int t = 0; t < 60 && !found; t++) begin
            step();
            if (in_flight && (cyc - acc_cyc) == 1) found = 1'b1;
        end
        check("reset_wait_reached", found, 1'b1);
        rst = 1'b1;
        #1;
        gen_en  = 1'b0;
        rdy_all = 1'b1;
        for (int i = 0; i < N; i++) new_op(i);
        drive_reqs();
        #1;
        check_reset_values();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_cycle();
        check("post_rst_grant0", req_ready, NREQ'(1));
        repeat (30) step();
        check("post_rst_ops_done", ops_done, 16'(N));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
